// File: rtl/exu_bjp_cmtq.sv
// In-order commit-request queue between the ALU/BJP datapath and the
// branch resolver, with a saturating count of retired mispredicts.
module exu_bjp_cmtq #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32,
  parameter int XW    = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            alu_i_valid,
  output logic            alu_i_ready,
  input  logic            alu_i_bjp,
  input  logic            alu_i_bjp_prdt,
  input  logic            alu_i_bjp_rslv,
  input  logic [PC_W-1:0] alu_i_pc,
  input  logic [XW-1:0]   alu_i_imm,
  output logic            cmt_o_valid,
  input  logic            cmt_o_ready,
  output logic            cmt_o_bjp,
  output logic            cmt_o_bjp_prdt,
  output logic            cmt_o_bjp_rslv,
  output logic [PC_W-1:0] cmt_o_pc,
  output logic [XW-1:0]   cmt_o_imm,
  output logic [AW:0]     occ_o,
  output logic [31:0]     mispred_cnt_o
);

  typedef struct packed {
    logic            bjp;
    logic            prdt;
    logic            rslv;
    logic [PC_W-1:0] pc;
    logic [XW-1:0]   imm;
  } ent_t;

  ent_t        mem_q [DEPTH];
  ent_t        mem_d [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  logic full, empty, push, pop, mispred;
  ent_t head;

  // Extra wrap bit distinguishes full from empty when indices match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign alu_i_ready = ~rst & ~full & ~flush_i;
  assign cmt_o_valid = ~empty;

  assign push    = alu_i_valid & alu_i_ready;
  assign pop     = cmt_o_valid & cmt_o_ready & ~flush_i;
  assign mispred = pop & head.bjp & (head.prdt ^ head.rslv);

  assign occ_o         = wr_ptr_q - rd_ptr_q;
  assign mispred_cnt_o = mispred_cnt_q;

  always_comb begin
    cmt_o_bjp      = 1'b0;
    cmt_o_bjp_prdt = 1'b0;
    cmt_o_bjp_rslv = 1'b0;
    cmt_o_pc       = '0;
    cmt_o_imm      = '0;
    if (cmt_o_valid) begin
      cmt_o_bjp      = head.bjp;
      cmt_o_bjp_prdt = head.prdt;
      cmt_o_bjp_rslv = head.rslv;
      cmt_o_pc       = head.pc;
      cmt_o_imm      = head.imm;
    end
  end

  always_comb begin
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mispred_cnt_d = mispred_cnt_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = '{
          bjp:  alu_i_bjp,
          prdt: alu_i_bjp_prdt,
          rslv: alu_i_bjp_rslv,
          pc:   alu_i_pc,
          imm:  alu_i_imm
        };
        wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      if (mispred && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
        mispred_cnt_d = mispred_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Entry storage needs no reset: outputs are gated by cmt_o_valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
